// File: rtl/rackctl_wb_responder.sv
// rtl/rackctl_wb_responder.sv - serial RACKCTL request to Wishbone master bridge with serial status/data response
// A request frame is shifted straight into the Wishbone output registers; the termination status (and read data) is shifted back out.
module rackctl_wb_responder #(
   parameter int unsigned TIMEOUT = 255,
   parameter logic        INV     = 1'b0
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n_i,
   input  logic        rack_rx_i,
   output logic        rack_tx_o,
   output logic        rack_txen_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [21:0] wb_adr_o,
   output logic [3:0]  wb_sel_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   input  logic        wb_rty_i,
   output logic        busy_o,
   output logic        frame_err_o
);

   localparam int TO_W = $clog2(TIMEOUT + 1);

   typedef enum logic [3:0] {
      IDLE, RX_ADR, RX_SEL, RX_DAT, RX_STOP, WB,
      TX_TURN, TX_START, TX_STAT, TX_DAT, TX_STOP
   } state_t;

   state_t            state, next_state;
   logic [4:0]        bit_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic [1:0]        status;
   logic [31:0]       tx_sr;
   logic              rx;
   logic              tx_bit;
   logic              last_bit;
   logic              to_expired;
   logic              term;
   logic              rd_resp;

   assign rx         = rack_rx_i ^ INV;
   assign rack_tx_o  = tx_bit ^ INV;
   assign last_bit   = (bit_cnt == 5'd0);
   assign to_expired = (to_cnt >= TO_W'(TIMEOUT - 1));
   assign term       = wb_ack_i | wb_err_i | wb_rty_i;
   assign rd_resp    = !wb_we_o && (status == 2'b00);

   // The we bit is the first bit of RX_ADR; on the final address bit it sits in wb_adr_o[21].
   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (!rx) next_state = RX_ADR;
         RX_ADR:   if (last_bit) next_state = wb_adr_o[21] ? RX_SEL : RX_STOP;
         RX_SEL:   if (last_bit) next_state = RX_DAT;
         RX_DAT:   if (last_bit) next_state = RX_STOP;
         RX_STOP:  next_state = rx ? WB : IDLE;
         WB:       if (term || to_expired) next_state = TX_TURN;
         TX_TURN:  if (last_bit) next_state = TX_START;
         TX_START: next_state = TX_STAT;
         TX_STAT:  if (last_bit) next_state = rd_resp ? TX_DAT : TX_STOP;
         TX_DAT:   if (last_bit) next_state = TX_STOP;
         TX_STOP:  next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   always_comb begin
      busy_o      = (state != IDLE);
      wb_cyc_o    = (state == WB);
      wb_stb_o    = (state == WB);
      rack_txen_o = 1'b0;
      tx_bit      = 1'b1;
      case (state)
         TX_TURN:  rack_txen_o = 1'b1;
         TX_START: begin
            rack_txen_o = 1'b1;
            tx_bit      = 1'b0;
         end
         TX_STAT:  begin
            rack_txen_o = 1'b1;
            tx_bit      = status[bit_cnt[0]];
         end
         TX_DAT:   begin
            rack_txen_o = 1'b1;
            tx_bit      = tx_sr[31];
         end
         TX_STOP:  rack_txen_o = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         state       <= IDLE;
         bit_cnt     <= 5'd0;
         to_cnt      <= '0;
         status      <= 2'b00;
         tx_sr       <= 32'd0;
         wb_we_o     <= 1'b0;
         wb_adr_o    <= 22'd0;
         wb_sel_o    <= 4'd0;
         wb_dat_o    <= 32'd0;
         frame_err_o <= 1'b0;
      end else begin
         state       <= next_state;
         frame_err_o <= (state == RX_STOP) && !rx;

         // Every field entry reloads its own length, so a field can never run into the next.
         if (next_state != state) begin
            case (next_state)
               RX_ADR:          bit_cnt <= 5'd22;
               RX_SEL:          bit_cnt <= 5'd3;
               RX_DAT, TX_DAT:  bit_cnt <= 5'd31;
               TX_TURN, TX_STAT: bit_cnt <= 5'd1;
               default:         bit_cnt <= 5'd0;
            endcase
         end else if (!last_bit) begin
            bit_cnt <= bit_cnt - 5'd1;
         end

         case (state)
            RX_ADR: begin
               {wb_we_o, wb_adr_o} <= {wb_adr_o, rx};
               if (next_state == RX_STOP) begin
                  wb_sel_o <= 4'hF;
                  wb_dat_o <= 32'd0;
               end
            end
            RX_SEL:  wb_sel_o <= {wb_sel_o[2:0], rx};
            RX_DAT:  wb_dat_o <= {wb_dat_o[30:0], rx};
            RX_STOP: to_cnt   <= '0;
            WB: begin
               if (!to_expired) to_cnt <= to_cnt + 1'b1;
               if (wb_ack_i) begin
                  status <= 2'b00;
                  tx_sr  <= wb_dat_i;
               end else if (wb_err_i) begin
                  status <= 2'b01;
               end else if (wb_rty_i) begin
                  status <= 2'b10;
               end else if (to_expired) begin
                  status <= 2'b11;
               end
            end
            TX_DAT:  tx_sr <= {tx_sr[30:0], 1'b0};
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rackctl_wb_responder.sv
// tb/tb_rackctl_wb_responder.sv - directed bench for rackctl_wb_responder, normal and inverted instances
module tb_rackctl_wb_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx;
   logic        rxi;
   logic [31:0] rdat;
   logic        s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0, late_ack = 1'b0;
   logic        ack, err, rty;

   logic        tx, txen, cyc, stb, we, busy, ferr;
   logic [21:0] adr;
   logic [3:0]  sel;
   logic [31:0] dat;
   logic        i_tx, i_txen, i_cyc, i_stb, i_we, i_busy, i_ferr;
   logic [21:0] i_adr;
   logic [3:0]  i_sel;
   logic [31:0] i_dat;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign ack = s_ack | late_ack;
   assign err = s_err;
   assign rty = s_rty;
   assign rxi = ~rx;

   rackctl_wb_responder dut (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n), .rack_rx_i(rx), .rack_tx_o(tx), .rack_txen_o(txen),
      .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr), .wb_sel_o(sel),
      .wb_dat_o(dat), .wb_dat_i(rdat), .wb_ack_i(ack), .wb_err_i(err), .wb_rty_i(rty),
      .busy_o(busy), .frame_err_o(ferr)
   );

   rackctl_wb_responder #(.TIMEOUT(255), .INV(1'b1)) dut_i (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n), .rack_rx_i(rxi), .rack_tx_o(i_tx), .rack_txen_o(i_txen),
      .wb_cyc_o(i_cyc), .wb_stb_o(i_stb), .wb_we_o(i_we), .wb_adr_o(i_adr), .wb_sel_o(i_sel),
      .wb_dat_o(i_dat), .wb_dat_i(rdat), .wb_ack_i(ack), .wb_err_i(err), .wb_rty_i(rty),
      .busy_o(i_busy), .frame_err_o(i_ferr)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Slave: terminates per slv_mode once stb has been seen slv_delay times.
   int slv_mode  = 0;
   int slv_delay = 1;
   int stb_cnt   = 0;
   always @(posedge clk) begin
      #1;
      s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
      if (cyc && stb) begin
         stb_cnt++;
         if (stb_cnt == slv_delay) begin
            case (slv_mode)
               1: s_ack = 1'b1;
               2: s_err = 1'b1;
               3: begin s_ack = 1'b1; s_err = 1'b1; end
               4: s_rty = 1'b1;
               5: begin s_err = 1'b1; s_rty = 1'b1; end
               default: ;
            endcase
         end
      end else begin
         stb_cnt = 0;
      end
   end

   int          ncyc, cyc_len, ntx, nti, nferr, unstable;
   logic        cyc_prev = 1'b0;
   logic [63:0] tx_bits, txi_bits;
   logic [21:0] cap_adr;
   logic [3:0]  cap_sel;
   logic [31:0] cap_dat;
   logic        cap_we;

   always @(negedge clk) begin
      if (cyc) begin
         if (!cyc_prev) ncyc++;
         if (cyc_len > 0 && (adr != cap_adr || sel != cap_sel || dat != cap_dat || we != cap_we))
            unstable++;
         if (stb !== cyc || i_cyc !== cyc || i_adr !== adr || i_we !== we) unstable++;
         cap_adr = adr; cap_sel = sel; cap_dat = dat; cap_we = we;
         cyc_len++;
      end
      cyc_prev = cyc;
      if (txen) begin
         tx_bits = {tx_bits[62:0], tx};
         ntx++;
      end
      if (i_txen) begin
         txi_bits = {txi_bits[62:0], i_tx};
         nti++;
      end
      if (ferr) nferr++;
   end

   task automatic clear_mon();
      ncyc = 0; cyc_len = 0; ntx = 0; nti = 0; nferr = 0; unstable = 0;
      tx_bits = 64'd0; txi_bits = 64'd0;
      cap_adr = 22'd0; cap_sel = 4'd0; cap_dat = 32'd0; cap_we = 1'b0;
   endtask

   task automatic send_frame(input logic w, input logic [21:0] a, input logic [3:0] s,
                             input logic [31:0] d, input logic stop);
      logic [60:0] bits;
      int n;
      if (w) begin
         bits = {1'b0, 1'b1, a, s, d, stop};
         n    = 61;
      end else begin
         bits = 61'({1'b0, 1'b0, a, stop});
         n    = 25;
      end
      for (int i = n - 1; i >= 0; i--) begin
         @(posedge clk); #1 rx = bits[i];
      end
      @(posedge clk); #1 rx = 1'b1;
   endtask

   task automatic wait_idle(input int max_cyc);
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check_eq("idle_reached", 64'(busy), 64'd0);
      @(posedge clk); #1;
   endtask

   task automatic run_write(input int mode, input int dly, input logic [5:0] exp_resp, input string tag);
      clear_mon();
      slv_mode = mode; slv_delay = dly;
      send_frame(1'b1, 22'h00A5A, 4'h3, 32'h0F0F1234, 1'b1);
      wait_idle(400);
      check_eq({tag, "_ntx"},  64'(ntx), 64'd6);
      check_eq({tag, "_resp"}, tx_bits, 64'(exp_resp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; rx = 1'b1; rdat = 32'd0;
      clear_mon();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_cyc",  64'(cyc),  64'd0);
      check_eq("rst_stb",  64'(stb),  64'd0);
      check_eq("rst_we",   64'(we),   64'd0);
      check_eq("rst_txen", 64'(txen), 64'd0);
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_ferr", 64'(ferr), 64'd0);
      check_eq("rst_tx",   64'(tx),   64'd1);
      check_eq("rst_adr",  64'(adr),  64'd0);
      check_eq("rst_sel",  64'(sel),  64'd0);
      check_eq("rst_dat",  64'(dat),  64'd0);
      check_eq("rst_inv_tx", 64'(i_tx), 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(posedge clk); #1;

      // write, ack on third stb cycle
      clear_mon();
      slv_mode = 1; slv_delay = 3;
      send_frame(1'b1, 22'h000123, 4'hF, 32'hDEADBEEF, 1'b1);
      wait_idle(400);
      check_eq("wr_ncyc",     64'(ncyc),     64'd1);
      check_eq("wr_we",       64'(cap_we),   64'd1);
      check_eq("wr_adr",      64'(cap_adr),  64'h000123);
      check_eq("wr_sel",      64'(cap_sel),  64'hF);
      check_eq("wr_dat",      64'(cap_dat),  64'hDEADBEEF);
      check_eq("wr_stable",   64'(unstable), 64'd0);
      check_eq("wr_cyc_len",  64'(cyc_len),  64'd3);
      check_eq("wr_ntx",      64'(ntx),      64'd6);
      check_eq("wr_resp",     tx_bits,       64'h31);
      check_eq("wr_inv_ntx",  64'(nti),      64'd6);
      check_eq("wr_inv_resp", txi_bits,      64'h0E);
      check_eq("wr_inv_adr",  64'(i_adr),    64'h000123);
      check_eq("wr_inv_dat",  64'(i_dat),    64'hDEADBEEF);
      check_eq("idle_tx",     64'(tx),       64'd1);
      check_eq("idle_inv_tx", 64'(i_tx),     64'd0);

      // read with ack and data
      clear_mon();
      slv_mode = 1; slv_delay = 1; rdat = 32'hCAFEF00D;
      send_frame(1'b0, 22'h3FFFFF, 4'h0, 32'd0, 1'b1);
      wait_idle(400);
      check_eq("rd_ncyc",    64'(ncyc),    64'd1);
      check_eq("rd_we",      64'(cap_we),  64'd0);
      check_eq("rd_sel",     64'(cap_sel), 64'hF);
      check_eq("rd_adr",     64'(cap_adr), 64'h3FFFFF);
      check_eq("rd_cyc_len", 64'(cyc_len), 64'd1);
      check_eq("rd_ntx",     64'(ntx),     64'd38);
      check_eq("rd_resp",    tx_bits,      64'({5'b11000, 32'hCAFEF00D, 1'b1}));
      check_eq("rd_inv_ntx", 64'(nti),     64'd38);

      // read with no termination
      clear_mon();
      slv_mode = 0; rdat = 32'h11111111;
      send_frame(1'b0, 22'h000015, 4'h0, 32'd0, 1'b1);
      wait_idle(600);
      check_eq("to_ncyc",    64'(ncyc),    64'd1);
      check_eq("to_cyc_len", 64'(cyc_len), 64'd255);
      check_eq("to_ntx",     64'(ntx),     64'd6);
      check_eq("to_resp",    tx_bits,      64'h37);

      // bad stop bit
      clear_mon();
      slv_mode = 1; slv_delay = 1;
      send_frame(1'b1, 22'h000200, 4'hA, 32'h55AA55AA, 1'b0);
      @(negedge clk);
      check_eq("fe_pulse", 64'(ferr), 64'd1);
      check_eq("fe_busy",  64'(busy), 64'd0);
      repeat (5) @(posedge clk); #1;
      check_eq("fe_count", 64'(nferr), 64'd1);
      check_eq("fe_ncyc",  64'(ncyc),  64'd0);
      check_eq("fe_ntx",   64'(ntx),   64'd0);

      // termination priority
      run_write(3, 2, 6'b110001, "ack_err");
      run_write(2, 1, 6'b110011, "err");
      run_write(5, 2, 6'b110011, "err_rty");
      run_write(4, 1, 6'b110101, "rty");

      // reset during WB, late ack ignored, then a fresh read
      clear_mon();
      slv_mode = 0;
      send_frame(1'b0, 22'h000010, 4'h0, 32'd0, 1'b1);
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check_eq("rstwb_cyc",  64'(cyc),  64'd0);
      check_eq("rstwb_busy", 64'(busy), 64'd0);
      @(posedge clk); #1 late_ack = 1'b1;
      @(posedge clk); #1 late_ack = 1'b0;
      repeat (4) @(posedge clk); #1;
      check_eq("rstwb_ntx",  64'(ntx),  64'd0);
      check_eq("rstwb_ncyc", 64'(ncyc), 64'd1);
      check_eq("rstwb_idle", 64'(busy), 64'd0);
      clear_mon();
      slv_mode = 1; slv_delay = 2; rdat = 32'h12345678;
      send_frame(1'b0, 22'h000004, 4'h0, 32'd0, 1'b1);
      wait_idle(400);
      check_eq("rd2_adr",  64'(cap_adr), 64'h000004);
      check_eq("rd2_ntx",  64'(ntx),     64'd38);
      check_eq("rd2_resp", tx_bits,      64'({5'b11000, 32'h12345678, 1'b1}));

      // reset during response
      clear_mon();
      slv_mode = 1; slv_delay = 1; rdat = 32'hA5A5A5A5;
      send_frame(1'b0, 22'h000008, 4'h0, 32'd0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (txen) break;
      end
      check_eq("rsttx_txen_seen", 64'(txen), 64'd1);
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check_eq("rsttx_txen", 64'(txen), 64'd0);
      check_eq("rsttx_tx",   64'(tx),   64'd1);
      check_eq("rsttx_busy", 64'(busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
